// File: rtl/scoreboard_cmd_scheduler.sv
// Button front end for the 00-99 scoreboard counter: synchronise, debounce, arbitrate, and issue one-cycle incr/decr/clr commands.
// Define SCB_AUTOREPEAT_EN to build the hold/auto-repeat path; without it each press yields exactly one command.
module scoreboard_cmd_scheduler #(
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned DEB_TICKS    = 4,
    parameter int unsigned HOLD_TICKS   = 50,
    parameter int unsigned REPEAT_TICKS = 10,
    parameter int unsigned CNT_W        = 8
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_tick,
    input  logic i_btn_incr,
    input  logic i_btn_decr,
    input  logic i_btn_clr,
    output logic o_cmd_incr,
    output logic o_cmd_decr,
    output logic o_cmd_clr,
    output logic o_busy
);

    localparam int unsigned N_BTN = 3;

    localparam logic [1:0] S_IDLE   = 2'd0;
`ifdef SCB_AUTOREPEAT_EN
    localparam logic [1:0] S_HOLD   = 2'd1;
    localparam logic [1:0] S_REPEAT = 2'd2;
`endif
    localparam logic [1:0] S_LOCK   = 2'd3;

    localparam logic [2:0] CMD_INCR = 3'b001;
    localparam logic [2:0] CMD_DECR = 3'b010;
    localparam logic [2:0] CMD_CLR  = 3'b100;

    // Reject configurations the counters cannot represent
    if (SYNC_STAGES < 2 || DEB_TICKS == 0 || HOLD_TICKS == 0 || REPEAT_TICKS == 0 ||
        (DEB_TICKS >> CNT_W) != 0 || (HOLD_TICKS >> CNT_W) != 0 ||
        (REPEAT_TICKS >> CNT_W) != 0) begin : g_cfg_err
        $error("scoreboard_cmd_scheduler: invalid parameter set");
    end

    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] deb_lvl;

    assign btn_raw = {i_btn_clr, i_btn_decr, i_btn_incr};

    // Per-button synchroniser and tick-paced debouncer
    for (genvar g = 0; g < N_BTN; g++) begin : g_btn
        logic [SYNC_STAGES-1:0] sync_q;
        logic [CNT_W-1:0]       deb_cnt_q;
        logic                   deb_q;

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                sync_q    <= '0;
                deb_cnt_q <= '0;
                deb_q     <= 1'b0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw[g]};
                if (i_tick) begin
                    if (sync_q[SYNC_STAGES-1] == deb_q) begin
                        deb_cnt_q <= '0;
                    end else if (deb_cnt_q == CNT_W'(DEB_TICKS - 1)) begin
                        deb_cnt_q <= '0;
                        deb_q     <= ~deb_q;
                    end else begin
                        deb_cnt_q <= deb_cnt_q + CNT_W'(1);
                    end
                end
            end
        end

        assign deb_lvl[g] = deb_q;
    end

    logic d_inc;
    logic d_dec;
    logic d_clr;
    logic d_kill;

    assign d_inc  = deb_lvl[0];
    assign d_dec  = deb_lvl[1];
    assign d_clr  = deb_lvl[2];
    assign d_kill = d_clr | (d_inc & d_dec);

    logic [1:0] state_q;
    logic [1:0] state_n;
    logic [2:0] cmd_q;
    logic [2:0] cmd_n;
    logic       busy_q;

`ifdef SCB_AUTOREPEAT_EN
    logic             dir_q;
    logic             dir_n;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_n;
    logic             dir_held;

    // dir 0 = increment, 1 = decrement
    assign dir_held = dir_q ? d_dec : d_inc;
`endif

    // Next-state and command selection; clr beats both-directions beats release beats repeat
    always_comb begin
        state_n = state_q;
        cmd_n   = '0;
`ifdef SCB_AUTOREPEAT_EN
        dir_n   = dir_q;
        cnt_n   = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (d_kill) begin
                    cmd_n   = CMD_CLR;
                    state_n = S_LOCK;
                end else if (d_inc ^ d_dec) begin
                    cmd_n   = d_inc ? CMD_INCR : CMD_DECR;
`ifdef SCB_AUTOREPEAT_EN
                    dir_n   = d_dec;
                    cnt_n   = CNT_W'(HOLD_TICKS);
                    state_n = S_HOLD;
`else
                    state_n = S_LOCK;
`endif
                end
            end
`ifdef SCB_AUTOREPEAT_EN
            S_HOLD, S_REPEAT: begin
                if (d_kill) begin
                    cmd_n   = CMD_CLR;
                    state_n = S_LOCK;
                end else if (!dir_held) begin
                    state_n = S_IDLE;
                end else if (i_tick) begin
                    if (cnt_q == CNT_W'(1)) begin
                        cmd_n   = dir_q ? CMD_DECR : CMD_INCR;
                        cnt_n   = CNT_W'(REPEAT_TICKS);
                        state_n = S_REPEAT;
                    end else begin
                        cnt_n = cnt_q - CNT_W'(1);
                    end
                end
            end
`endif
            S_LOCK: begin
                if (!(d_inc | d_dec | d_clr)) begin
                    state_n = S_IDLE;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            cmd_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            cmd_q   <= cmd_n;
            busy_q  <= (state_n != S_IDLE);
        end
    end

`ifdef SCB_AUTOREPEAT_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            dir_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            dir_q <= dir_n;
            cnt_q <= cnt_n;
        end
    end
`endif

    assign o_cmd_incr = cmd_q[0];
    assign o_cmd_decr = cmd_q[1];
    assign o_cmd_clr  = cmd_q[2];
    assign o_busy     = busy_q;

endmodule

// File: tb/tb_scoreboard_cmd_scheduler.sv
// Directed bench for scoreboard_cmd_scheduler: expected command pulses (cycle + kind) are queued at stimulus time and matched as the DUT emits them.
// Expectations follow SCB_AUTOREPEAT_EN the same way the design build does.
module tb_scoreboard_cmd_scheduler;

    localparam int DEB      = 4;
    localparam int HOLD     = 5;
    localparam int REP      = 2;
    localparam int TICK_DIV = 4;

    localparam logic [2:0] C_NONE = 3'b000;
    localparam logic [2:0] C_INCR = 3'b001;
    localparam logic [2:0] C_DECR = 3'b010;
    localparam logic [2:0] C_CLR  = 3'b100;

    logic i_clk;
    logic i_rst;
    logic i_tick;
    logic i_btn_incr;
    logic i_btn_decr;
    logic i_btn_clr;
    logic o_cmd_incr;
    logic o_cmd_decr;
    logic o_cmd_clr;
    logic o_busy;

    scoreboard_cmd_scheduler #(
        .SYNC_STAGES (2),
        .DEB_TICKS   (DEB),
        .HOLD_TICKS  (HOLD),
        .REPEAT_TICKS(REP),
        .CNT_W       (8)
    ) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_tick     (i_tick),
        .i_btn_incr (i_btn_incr),
        .i_btn_decr (i_btn_decr),
        .i_btn_clr  (i_btn_clr),
        .o_cmd_incr (o_cmd_incr),
        .o_cmd_decr (o_cmd_decr),
        .o_cmd_clr  (o_cmd_clr),
        .o_busy     (o_busy)
    );

    initial begin
        i_clk = 1'b1;
        forever #5 i_clk = ~i_clk;
    end

    typedef struct {
        int         cyc;
        logic [2:0] cmd;
    } exp_t;

    exp_t exp_q[$];
    int   cyc_n;
    int   errors;
    int   checks;
    bit   mon_en;

    task automatic chk3(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Cycle of the debounce flip for a raw change driven at cycle a (4th tick seen after the 2-flop sync)
    function automatic int deb_tick(input int a);
        int k;
        k = a + 2;
        while (k % TICK_DIV != 0) k++;
        return k + (DEB - 1) * TICK_DIV;
    endfunction

    function automatic logic [2:0] cmd_for(input logic [2:0] btn);
        if (btn[2] || (btn[0] && btn[1])) return C_CLR;
        return btn[1] ? C_DECR : C_INCR;
    endfunction

    task automatic push_exp(input int c, input logic [2:0] cmd);
        exp_t e;
        int   i;
        e.cyc = c;
        e.cmd = cmd;
        i = 0;
        while (i < exp_q.size() && exp_q[i].cyc <= c) i++;
        exp_q.insert(i, e);
    endtask

    // One clock: sample outputs at the falling edge, score them, then drive the tick strobe
    task automatic cyc();
        logic [2:0] obs;
        logic [2:0] exp;
        @(negedge i_clk);
        cyc_n++;
        if (mon_en) begin
            obs = {o_cmd_clr, o_cmd_decr, o_cmd_incr};
            exp = C_NONE;
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc_n) begin
                exp = exp_q[0].cmd;
                void'(exp_q.pop_front());
            end
            if (obs !== C_NONE || exp !== C_NONE)
                chk3($sformatf("cmd@%0d", cyc_n), obs, exp);
        end
        i_tick = (cyc_n % TICK_DIV == 0);
    endtask

    task automatic run_to(input int k);
        while (cyc_n < k) cyc();
    endtask

    task automatic press_release(input string tag, input logic [2:0] btn, input int hold);
        int         a;
        int         t;
        int         t2;
        int         rt;
        logic [2:0] c;
        a  = cyc_n;
        c  = cmd_for(btn);
        {i_btn_clr, i_btn_decr, i_btn_incr} = btn;
        t  = deb_tick(a);
        t2 = deb_tick(a + hold);
        push_exp(t + 2, c);
`ifdef SCB_AUTOREPEAT_EN
        if (c != C_CLR) begin
            rt = t + HOLD * TICK_DIV;
            while (rt <= t2) begin
                push_exp(rt + 1, c);
                rt += REP * TICK_DIV;
            end
        end
`else
        rt = 0;
`endif
        run_to(a + hold);
        {i_btn_clr, i_btn_decr, i_btn_incr} = 3'b000;
        run_to(t + 2);
        chk1({tag, ":busy_active"}, o_busy, 1'b1);
        run_to(t2 + 4);
        chk1({tag, ":busy_idle"}, o_busy, 1'b0);
    endtask

    initial begin
        int a;
        int b;
        int t;
        int td;
        int tc;
        int rt;

        errors = 0;
        checks = 0;
        cyc_n  = 0;
        mon_en = 0;
        i_rst  = 1'b1;
        i_tick = 1'b0;
        {i_btn_clr, i_btn_decr, i_btn_incr} = 3'b111;

        // Reset with all buttons held: silent during reset and the cycle after, then a clr
        cyc();
        mon_en = 1;
        repeat (3) begin
            cyc();
            chk3("reset_cmd", {o_cmd_clr, o_cmd_decr, o_cmd_incr}, C_NONE);
            chk1("reset_busy", o_busy, 1'b0);
        end
        i_rst = 1'b0;
        push_exp(deb_tick(cyc_n) + 2, C_CLR);
        cyc();
        chk3("post_reset_cmd", {o_cmd_clr, o_cmd_decr, o_cmd_incr}, C_NONE);
        chk1("post_reset_busy", o_busy, 1'b0);
        run_to(deb_tick(4) + 6);
        chk1("reset_lock_busy", o_busy, 1'b1);
        {i_btn_clr, i_btn_decr, i_btn_incr} = 3'b000;
        run_to(deb_tick(cyc_n) + 4);
        chk1("reset_release_busy", o_busy, 1'b0);

        // Bouncing incr never settles long enough to produce a command
        for (int i = 0; i < 40; i++) begin
            if (i % 6 == 0) i_btn_incr = ~i_btn_incr;
            cyc();
        end
        i_btn_incr = 1'b0;
        run_to(cyc_n + 40);
        chk1("bounce_busy", o_busy, 1'b0);

        // Stable incr press: single pulse one cycle after the accepting tick
        press_release("incr_single", C_INCR, 16);

        // Long decr hold: auto-repeat when built, single pulse otherwise
        press_release("decr_hold", C_DECR, 120);

        // Opposite direction pressed during repeat -> clr, then locked until all released
        a = cyc_n;
        i_btn_incr = 1'b1;
        t = deb_tick(a);
        push_exp(t + 2, C_INCR);
        run_to(t + 22);
        b = cyc_n;
        i_btn_decr = 1'b1;
        td = deb_tick(b);
`ifdef SCB_AUTOREPEAT_EN
        rt = t + HOLD * TICK_DIV;
        while (rt <= td) begin
            push_exp(rt + 1, C_INCR);
            rt += REP * TICK_DIV;
        end
        push_exp(td + 2, C_CLR);
`else
        rt = 0;
`endif
        run_to(td + 20);
        chk1("both_lock_busy", o_busy, 1'b1);
        {i_btn_clr, i_btn_decr, i_btn_incr} = 3'b000;
        tc = deb_tick(cyc_n);
        run_to(tc + 1);
        chk1("both_lock_hold", o_busy, 1'b1);
        cyc();
        chk1("both_lock_exit", o_busy, 1'b0);

        // clr and incr together from IDLE: clr only
        press_release("clr_prio", C_CLR | C_INCR, 40);

        // Two separate incr presses, each with its own command sequence
        press_release("incr_press1", C_INCR, 120);
        run_to(cyc_n + 20);
        press_release("incr_press2", C_INCR, 40);

        run_to(cyc_n + 10);
        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL pending_expected: observed=%0d expected=0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
